// File: rtl/fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_buf
// Description : Single-clock synchronous FIFO with occupancy count,
//               programmable almost-full/almost-empty thresholds, one-cycle
//               overflow/underflow error pulses and a selectable read mode
//               (show-ahead or registered output).
// Ports       : wclk          - sole clock, rising edge
//               wrst_n        - asynchronous active-low reset
//               winc / wdata  - write request and data
//               rinc / rdata  - read request and data
//               wfull, rempty - count == DEPTH / count == 0
//               almost_full   - count >= AFULL_TH
//               almost_empty  - count <= AEMPTY_TH
//               count         - occupancy, 0..DEPTH
//               overflow      - pulse: write attempted while full
//               underflow     - pulse: read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_buf #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int AFULL_TH  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit REG_OUT   = 1'b0
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int c_DEPTH = 1 << ADDR_SIZE;
    localparam int c_PW    = ADDR_SIZE + 1;

    localparam logic [ADDR_SIZE:0] c_DEPTH_CNT = c_PW'(c_DEPTH);
    localparam logic [ADDR_SIZE:0] c_AFULL_CNT = c_PW'(AFULL_TH);
    localparam logic [ADDR_SIZE:0] c_AEMPT_CNT = c_PW'(AEMPTY_TH);

    logic [DATA_SIZE-1:0] r_mem [c_DEPTH];

    logic [ADDR_SIZE:0] r_wptr;
    logic [ADDR_SIZE:0] r_rptr;
    logic [ADDR_SIZE:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_wr_en;
    logic               w_rd_en;
    logic [ADDR_SIZE:0] w_wptr_nxt;
    logic [ADDR_SIZE:0] w_rptr_nxt;

    // Flags come from the registered count only, so they never see a
    // combinational path from winc/rinc.
    assign wfull        = (r_count == c_DEPTH_CNT);
    assign rempty       = (r_count == '0);
    assign almost_full  = (r_count >= c_AFULL_CNT);
    assign almost_empty = (r_count <= c_AEMPT_CNT);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Acceptance uses the pre-edge flags: at full a simultaneous read still
    // goes through while the write is dropped, and vice versa at empty.
    assign w_wr_en    = winc && !wfull;
    assign w_rd_en    = rinc && !rempty;
    assign w_wptr_nxt = r_wptr + {{ADDR_SIZE{1'b0}}, w_wr_en};
    assign w_rptr_nxt = r_rptr + {{ADDR_SIZE{1'b0}}, w_rd_en};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            // With a wrap bit on each pointer the modular difference is the
            // exact occupancy 0..DEPTH, i.e. +1 on write-only, -1 on read-only.
            r_count     <= w_wptr_nxt - w_rptr_nxt;
            r_overflow  <= winc && wfull;
            r_underflow <= rinc && rempty;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge wclk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ADDR_SIZE-1:0]] <= wdata;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [DATA_SIZE-1:0] r_rdata;

            always_ff @(posedge wclk or negedge wrst_n) begin
                if (!wrst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_en) begin
                    r_rdata <= r_mem[r_rptr[ADDR_SIZE-1:0]];
                end
            end

            assign rdata = r_rdata;
        end else begin : g_show_ahead
            // Head word is presented as soon as it is in the array.
            assign rdata = r_mem[r_rptr[ADDR_SIZE-1:0]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_buf
// Description : Directed self-checking bench for fifo_sync_buf. Two instances
//               (show-ahead and registered output) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_buf;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;

    logic [7:0] rdata_f;
    logic       wfull_f, rempty_f, afull_f, aempty_f, ovf_f, unf_f;
    logic [2:0] count_f;

    logic [7:0] rdata_r;
    logic       wfull_r, rempty_r, afull_r, aempty_r, ovf_r, unf_r;
    logic [2:0] count_r;

    int checks   = 0;
    int failures = 0;

    fifo_sync_buf #(
        .DATA_SIZE (8),
        .ADDR_SIZE (2),
        .AFULL_TH  (3),
        .AEMPTY_TH (1),
        .REG_OUT   (1'b0)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata_f),
        .wfull        (wfull_f),
        .rempty       (rempty_f),
        .almost_full  (afull_f),
        .almost_empty (aempty_f),
        .count        (count_f),
        .overflow     (ovf_f),
        .underflow    (unf_f)
    );

    fifo_sync_buf #(
        .DATA_SIZE (8),
        .ADDR_SIZE (2),
        .AFULL_TH  (3),
        .AEMPTY_TH (1),
        .REG_OUT   (1'b1)
    ) dut_r (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wdata        (wdata),
        .rinc         (rinc),
        .rdata        (rdata_r),
        .wfull        (wfull_r),
        .rempty       (rempty_r),
        .almost_full  (afull_r),
        .almost_empty (aempty_r),
        .count        (count_r),
        .overflow     (ovf_r),
        .underflow    (unf_r)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full status vector of the show-ahead instance plus count of the
    // registered instance, which must always track it.
    task automatic chk_status(input string tag, input logic [2:0] cnt,
                              input logic full, input logic empty,
                              input logic af, input logic ae,
                              input logic ovf, input logic unf);
        chk({tag, ".count"},   32'(count_f),  32'(cnt));
        chk({tag, ".wfull"},   32'(wfull_f),  32'(full));
        chk({tag, ".rempty"},  32'(rempty_f), 32'(empty));
        chk({tag, ".afull"},   32'(afull_f),  32'(af));
        chk({tag, ".aempty"},  32'(aempty_f), 32'(ae));
        chk({tag, ".ovf"},     32'(ovf_f),    32'(ovf));
        chk({tag, ".unf"},     32'(unf_f),    32'(unf));
        chk({tag, ".count_r"}, 32'(count_r),  32'(cnt));
    endtask

    logic [7:0] vec [4];

    initial begin
        vec[0] = 8'hA1; vec[1] = 8'hB2; vec[2] = 8'hC3; vec[3] = 8'hD4;
        wrst_n = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
        tick(); tick();
        wrst_n = 1'b1;
        tick();

        // Reset / idle
        chk_status("reset", 3'd0, 0, 1, 0, 1, 0, 0);
        chk("reset.rdata_r", 32'(rdata_r), 32'h00);

        // Fill with A1..D4
        winc = 1'b1;
        wdata = vec[0]; tick(); chk_status("wr1", 3'd1, 0, 0, 0, 1, 0, 0);
        chk("wr1.head", 32'(rdata_f), 32'hA1);
        wdata = vec[1]; tick(); chk_status("wr2", 3'd2, 0, 0, 0, 0, 0, 0);
        wdata = vec[2]; tick(); chk_status("wr3", 3'd3, 0, 0, 1, 0, 0, 0);
        wdata = vec[3]; tick(); chk_status("wr4", 3'd4, 1, 0, 1, 0, 0, 0);

        // Write at full: dropped, overflow pulse for one cycle
        wdata = 8'hFF; tick(); chk_status("ovf", 3'd4, 1, 0, 1, 0, 1, 0);
        winc = 1'b0;   tick(); chk_status("ovf_end", 3'd4, 1, 0, 1, 0, 0, 0);

        // Drain in order
        rinc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain.head", 32'(rdata_f), 32'(vec[i]));
            tick();
            chk("drain.rdata_r", 32'(rdata_r), 32'(vec[i]));
            chk("drain.count", 32'(count_f), 32'(3 - i));
        end
        chk_status("drained", 3'd0, 0, 1, 0, 1, 0, 0);

        // Read at empty: ignored, underflow pulse
        tick(); chk_status("unf", 3'd0, 0, 1, 0, 1, 0, 1);
        chk("unf.rdata_r_hold", 32'(rdata_r), 32'hD4);
        rinc = 1'b0; tick(); chk_status("unf_end", 3'd0, 0, 1, 0, 1, 0, 0);

        // Full + simultaneous write/read: read wins, 0xEE dropped
        winc = 1'b1;
        wdata = 8'h11; tick(); wdata = 8'h22; tick();
        wdata = 8'h33; tick(); wdata = 8'h44; tick();
        chk_status("refill", 3'd4, 1, 0, 1, 0, 0, 0);
        rinc = 1'b1; wdata = 8'hEE; tick();
        chk_status("full_rw", 3'd3, 0, 0, 1, 0, 1, 0);
        chk("full_rw.rdata_r", 32'(rdata_r), 32'h11);
        winc = 1'b0;
        chk("full_rw.h1", 32'(rdata_f), 32'h22); tick();
        chk("full_rw.h2", 32'(rdata_f), 32'h33); tick();
        chk("full_rw.h3", 32'(rdata_f), 32'h44); tick();
        chk_status("full_rw_drained", 3'd0, 0, 1, 0, 1, 0, 0);
        chk("full_rw.rdata_r_last", 32'(rdata_r), 32'h44);

        // Empty + simultaneous: write wins, read ignored
        winc = 1'b1; rinc = 1'b1; wdata = 8'h55; tick();
        chk_status("empty_rw", 3'd1, 0, 0, 0, 1, 0, 1);
        chk("empty_rw.head", 32'(rdata_f), 32'h55);
        chk("empty_rw.rdata_r_stale", 32'(rdata_r), 32'h44);
        winc = 1'b0; tick();
        chk("empty_rw.rdata_r", 32'(rdata_r), 32'h55);
        chk_status("empty_rw_done", 3'd0, 0, 1, 0, 1, 0, 0);

        // 10 write/read pairs, pointers wrap past DEPTH several times
        rinc = 1'b0; winc = 1'b1; wdata = 8'h60; tick();
        rinc = 1'b1;
        for (int i = 1; i < 10; i++) begin
            wdata = 8'(8'h60 + i);
            chk("wrap.head", 32'(rdata_f), 32'(8'h60 + i - 1));
            tick();
            chk("wrap.rdata_r", 32'(rdata_r), 32'(8'h60 + i - 1));
            chk("wrap.count", 32'(count_f), 32'd1);
        end
        winc = 1'b0;
        chk("wrap.last_head", 32'(rdata_f), 32'h69);
        tick();
        chk("wrap.last_rdata_r", 32'(rdata_r), 32'h69);
        chk_status("wrap_done", 3'd0, 0, 1, 0, 1, 0, 0);
        rinc = 1'b0;

        // Asynchronous reset mid-burst with two words queued
        winc = 1'b1;
        wdata = 8'h81; tick(); wdata = 8'h82; tick();
        chk("pre_rst.count", 32'(count_f), 32'd2);
        #2 wrst_n = 1'b0;
        #1;
        chk_status("async_rst", 3'd0, 0, 1, 0, 1, 0, 0);
        chk("async_rst.rdata_r", 32'(rdata_r), 32'h00);
        winc = 1'b0;
        tick();
        wrst_n = 1'b1;
        tick();
        chk_status("post_rst", 3'd0, 0, 1, 0, 1, 0, 0);

        // Fresh traffic after reset
        winc = 1'b1; wdata = 8'h77; tick();
        winc = 1'b0;
        chk("post_rst.count", 32'(count_f), 32'd1);
        chk("post_rst.head", 32'(rdata_f), 32'h77);
        rinc = 1'b1; tick();
        rinc = 1'b0;
        chk("post_rst.rdata_r", 32'(rdata_r), 32'h77);
        chk_status("post_rst_done", 3'd0, 0, 1, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
